performance_counter_arbiter: RTL and testbench

Shares one software-visible snapshot register set between the three per-operation latency counters (program, read, erase) in the performance monitor. When a counter's averaging window closes, it raises its ready flag. The arbiter grants one counter at a time in round-robin order and captures that counter's cycle sum and request count. It then holds the snapshot until software acknowledges it, and finally pulses the counter's copy-complete input so the counter clears and restarts. It sits between the counter instances and the slave-register bank of the monitor core.

---
 rtl/performance_counter_arbiter_pkg.sv | 38 +++
 rtl/performance_counter_arbiter_rr_pick3.sv | 32 +++
 rtl/performance_counter_arbiter.sv | 176 +++++++++++++++++
 tb/tb_performance_counter_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/performance_counter_arbiter_pkg.sv
// Shared definitions for the performance-monitor snapshot arbiter:
// source encodings, FSM states, snapshot widths and small index helpers.
package performance_counter_arbiter_pkg;

    localparam int NUM_SRC     = 3;
    localparam int SRC_WD      = 2;
    localparam int SNAP_CNT_WD = 32;
    localparam int SNAP_REQ_WD = 12;

    localparam logic [SRC_WD-1:0] SRC_PROG  = 2'd0;
    localparam logic [SRC_WD-1:0] SRC_READ  = 2'd1;
    localparam logic [SRC_WD-1:0] SRC_ERASE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_HOLD     = 3'd4
    } arb_state_t;

    // Encoding 3 never names a source; fold it onto prog.
    function automatic logic [SRC_WD-1:0] src_legal(input logic [SRC_WD-1:0] src);
        return (src == 2'd3) ? SRC_PROG : src;
    endfunction

    // Circular (mod 3) add of a small offset (0..2) to a source index.
    function automatic logic [SRC_WD-1:0] src_add(input logic [SRC_WD-1:0] base,
                                                  input logic [SRC_WD-1:0] off);
        logic [2:0] sum;
        sum = {1'b0, src_legal(base)} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[SRC_WD-1:0];
    endfunction

endpackage

// File: rtl/performance_counter_arbiter_rr_pick3.sv
// Combinational 3-way round-robin selector: returns the first requesting
// source at or after the pointer, walking prog -> read -> erase -> prog.
module perf_rr_pick3
    import performance_counter_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SRC_WD-1:0]  i_ptr,
    output logic [SRC_WD-1:0]  o_gnt_idx,
    output logic               o_gnt_vld
);

    logic [SRC_WD-1:0] w_cand [NUM_SRC];
    logic [NUM_SRC-1:0] w_cand_hit;

    // Candidate gi is the source gi steps after the pointer.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign w_cand[gi]     = src_add(i_ptr, 2'(gi));
            assign w_cand_hit[gi] = i_req[w_cand[gi]];
        end
    endgenerate

    // Nearest candidate to the pointer wins.
    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_idx = SRC_PROG;
        if (w_cand_hit[2]) o_gnt_idx = w_cand[2];
        if (w_cand_hit[1]) o_gnt_idx = w_cand[1];
        if (w_cand_hit[0]) o_gnt_idx = w_cand[0];
    end

endmodule

// File: rtl/performance_counter_arbiter.sv
// Shares one software-visible snapshot register set between the prog, read
// and erase latency counters. Grants one ready counter at a time in
// round-robin order, captures its sum and request count, holds the snapshot
// until acknowledged, then pulses that counter's copy-complete input.
module performance_counter_arbiter
    import performance_counter_arbiter_pkg::*;
#(
    parameter int HOLDOFF = 3    // must be >= 2 so a released ready flag has dropped
) (
    input  logic                   i_bus_clk,
    input  logic                   i_bus_rst,
    input  logic                   i_enable,
    input  logic                   i_auto_ack,
    input  logic [NUM_SRC-1:0]     i_ready,
    input  logic [31:0]            i_prog_cnt,
    input  logic [31:0]            i_read_cnt,
    input  logic [31:0]            i_erase_cnt,
    input  logic [9:0]             i_prog_req_cnt,
    input  logic [11:0]            i_read_req_cnt,
    input  logic [9:0]             i_erase_req_cnt,
    input  logic                   i_snap_ack,
    output logic [NUM_SRC-1:0]     o_cp_cmplt,
    output logic [SNAP_CNT_WD-1:0] o_snap_cnt,
    output logic [SNAP_REQ_WD-1:0] o_snap_req_cnt,
    output logic [SRC_WD-1:0]      o_snap_src,
    output logic                   o_snap_valid,
    output logic [7:0]             o_snap_seq
);

    localparam int HOLD_WD = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [SRC_WD-1:0]      r_grant;
    logic [SRC_WD-1:0]      r_ptr;
    logic [HOLD_WD-1:0]     r_hold_cnt;
    logic [NUM_SRC-1:0]     r_cp_cmplt;
    logic [SNAP_CNT_WD-1:0] r_snap_cnt;
    logic [SNAP_REQ_WD-1:0] r_snap_req_cnt;
    logic [SRC_WD-1:0]      r_snap_src;
    logic                   r_snap_valid;
    logic [7:0]             r_snap_seq;

    logic [SRC_WD-1:0]      w_pick_idx;
    logic                   w_pick_vld;
    logic [SRC_WD-1:0]      w_grant_eff;
    logic [NUM_SRC-1:0]     w_gnt_onehot;
    logic [SNAP_CNT_WD-1:0] w_sel_cnt;
    logic [SNAP_REQ_WD-1:0] w_sel_req;
    logic                   w_hold_done;
    logic                   w_grant_load;
    logic                   w_capture;
    logic                   w_release;

    perf_rr_pick3 u_pick (
        .i_req     (i_ready),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_vld (w_pick_vld)
    );

    assign w_grant_eff = src_legal(r_grant);
    assign w_hold_done = (r_hold_cnt == HOLD_WD'(HOLDOFF - 1));

    // One-hot copy-complete vector for the granted source.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
            assign w_gnt_onehot[gi] = (w_grant_eff == 2'(gi));
        end
    endgenerate

    // Route the granted counter's sum and zero-extended request count.
    always_comb begin
        w_sel_cnt = i_prog_cnt;
        w_sel_req = {2'b00, i_prog_req_cnt};
        case (w_grant_eff)
            SRC_READ: begin
                w_sel_cnt = i_read_cnt;
                w_sel_req = i_read_req_cnt;
            end
            SRC_ERASE: begin
                w_sel_cnt = i_erase_cnt;
                w_sel_req = {2'b00, i_erase_req_cnt};
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
        if (i_bus_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-transition control strobes.
    always_comb begin
        w_state_next = r_state;
        w_grant_load = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && w_pick_vld) begin
                    w_grant_load = 1'b1;
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_snap_ack || i_auto_ack) begin
                    w_release    = 1'b1;
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Grant, pointer, snapshot and copy-complete registers; the pulse and
    // valid clear are registered on the WAIT_ACK exit so they coincide with RELEASE.
    always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
        if (i_bus_rst) begin
            r_grant        <= SRC_PROG;
            r_ptr          <= SRC_PROG;
            r_hold_cnt     <= '0;
            r_cp_cmplt     <= '0;
            r_snap_cnt     <= '0;
            r_snap_req_cnt <= '0;
            r_snap_src     <= SRC_PROG;
            r_snap_valid   <= 1'b0;
            r_snap_seq     <= '0;
        end else begin
            r_cp_cmplt <= '0;
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
            if (w_grant_load) begin
                r_grant <= w_pick_idx;
            end
            if (w_capture) begin
                r_snap_cnt     <= w_sel_cnt;
                r_snap_req_cnt <= w_sel_req;
                r_snap_src     <= w_grant_eff;
                r_snap_valid   <= 1'b1;
                r_snap_seq     <= r_snap_seq + 8'd1;
            end
            if (w_release) begin
                r_cp_cmplt   <= w_gnt_onehot;
                r_snap_valid <= 1'b0;
                r_ptr        <= src_add(r_grant, 2'd1);
            end
        end
    end

    assign o_cp_cmplt     = r_cp_cmplt;
    assign o_snap_cnt     = r_snap_cnt;
    assign o_snap_req_cnt = r_snap_req_cnt;
    assign o_snap_src     = r_snap_src;
    assign o_snap_valid   = r_snap_valid;
    assign o_snap_seq     = r_snap_seq;

endmodule

// File: tb/tb_performance_counter_arbiter.sv
// Directed bench for performance_counter_arbiter: latency, round-robin order,
// grant spacing, ack filtering, enable gating, reset abort and sequence wrap.
module tb_performance_counter_arbiter;

    localparam int HOLDOFF = 3;
    localparam int SPACING = 4 + HOLDOFF;

    logic        i_bus_clk = 1'b0;
    logic        i_bus_rst;
    logic        i_enable;
    logic        i_auto_ack;
    logic [2:0]  i_ready;
    logic [31:0] i_prog_cnt, i_read_cnt, i_erase_cnt;
    logic [9:0]  i_prog_req_cnt;
    logic [11:0] i_read_req_cnt;
    logic [9:0]  i_erase_req_cnt;
    logic        i_snap_ack;
    logic [2:0]  o_cp_cmplt;
    logic [31:0] o_snap_cnt;
    logic [11:0] o_snap_req_cnt;
    logic [1:0]  o_snap_src;
    logic        o_snap_valid;
    logic [7:0]  o_snap_seq;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] exp_cnt [3];
    logic [31:0] exp_req [3];

    always #5 i_bus_clk = ~i_bus_clk;

    always @(posedge i_bus_clk) cyc <= cyc + 1;

    performance_counter_arbiter #(.HOLDOFF(HOLDOFF)) dut (
        .i_bus_clk       (i_bus_clk),
        .i_bus_rst       (i_bus_rst),
        .i_enable        (i_enable),
        .i_auto_ack      (i_auto_ack),
        .i_ready         (i_ready),
        .i_prog_cnt      (i_prog_cnt),
        .i_read_cnt      (i_read_cnt),
        .i_erase_cnt     (i_erase_cnt),
        .i_prog_req_cnt  (i_prog_req_cnt),
        .i_read_req_cnt  (i_read_req_cnt),
        .i_erase_req_cnt (i_erase_req_cnt),
        .i_snap_ack      (i_snap_ack),
        .o_cp_cmplt      (o_cp_cmplt),
        .o_snap_cnt      (o_snap_cnt),
        .o_snap_req_cnt  (o_snap_req_cnt),
        .o_snap_src      (o_snap_src),
        .o_snap_valid    (o_snap_valid),
        .o_snap_seq      (o_snap_seq)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wait (bounded) for a copy-complete pulse; cp stays 0 if none arrives.
    task automatic wait_cp(input int budget, output logic [2:0] cp, output int at);
        cp = '0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_bus_clk);
            if (o_cp_cmplt != 3'b000) begin
                cp = o_cp_cmplt;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge i_bus_clk);
    endtask

    // All three counters ready at once under auto-ack; expects prog, read, erase.
    task automatic run_three(input bit persist, input int first_seq);
        logic [2:0] cp;
        int at, prev;
        exp_cnt[0] = 32'h0000_0111; exp_req[0] = 32'd17;
        exp_cnt[1] = 32'h0002_2222; exp_req[1] = 32'd4095;
        exp_cnt[2] = 32'h3333_0000; exp_req[2] = 32'd1023;
        i_prog_cnt  = exp_cnt[0]; i_prog_req_cnt  = 10'd17;
        i_read_cnt  = exp_cnt[1]; i_read_req_cnt  = 12'd4095;
        i_erase_cnt = exp_cnt[2]; i_erase_req_cnt = 10'd1023;
        i_auto_ack = 1'b1;
        i_ready    = 3'b111;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            wait_cp(20, cp, at);
            $display("txn persist=%0d cp=%b src=%0d seq=%0d cnt=0x%0h req=%0d cyc=%0d",
                     persist, cp, o_snap_src, o_snap_seq, o_snap_cnt, o_snap_req_cnt, at);
            check_val("rr_cp", {29'd0, cp}, 32'd1 << k);
            check_val("rr_src", {30'd0, o_snap_src}, k);
            check_val("rr_seq", {24'd0, o_snap_seq}, first_seq + k);
            check_val("rr_cnt", o_snap_cnt, exp_cnt[k]);
            check_val("rr_req", {20'd0, o_snap_req_cnt}, exp_req[k]);
            check_val("rr_valid", {31'd0, o_snap_valid}, 32'd0);
            if (k > 0) check_val("rr_spacing", at - prev, SPACING);
            prev = at;
            if (persist) begin
                @(negedge i_bus_clk);
                check_val("rr_pulse_width", {29'd0, o_cp_cmplt}, 32'd0);
            end
            i_ready[k] = 1'b0;
        end
        wait_cp(12, cp, at);
        check_val("rr_no_regrant", {29'd0, cp}, 32'd0);
        i_auto_ack = 1'b0;
        idle_cycles(2);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2:0] cp;
        int at;

        i_bus_rst = 1'b1; i_enable = 1'b1; i_auto_ack = 1'b0; i_ready = '0;
        i_prog_cnt = '0; i_read_cnt = '0; i_erase_cnt = '0;
        i_prog_req_cnt = '0; i_read_req_cnt = '0; i_erase_req_cnt = '0;
        i_snap_ack = 1'b0;
        idle_cycles(2);

        check_val("rst_valid", {31'd0, o_snap_valid}, 32'd0);
        check_val("rst_cp", {29'd0, o_cp_cmplt}, 32'd0);
        check_val("rst_cnt", o_snap_cnt, 32'd0);
        check_val("rst_seq", {24'd0, o_snap_seq}, 32'd0);
        i_bus_rst = 1'b0;
        @(negedge i_bus_clk);

        // Single erase snapshot acknowledged by software.
        i_erase_cnt = 32'h1234; i_erase_req_cnt = 10'd1000; i_ready = 3'b100;
        @(negedge i_bus_clk);
        check_val("t1_valid_latency", {31'd0, o_snap_valid}, 32'd0);
        @(negedge i_bus_clk);
        $display("txn erase src=%0d cnt=0x%0h req=%0d seq=%0d", o_snap_src, o_snap_cnt, o_snap_req_cnt, o_snap_seq);
        check_val("t1_valid", {31'd0, o_snap_valid}, 32'd1);
        check_val("t1_src", {30'd0, o_snap_src}, 32'd2);
        check_val("t1_cnt", o_snap_cnt, 32'h1234);
        check_val("t1_req", {20'd0, o_snap_req_cnt}, 32'd1000);
        check_val("t1_seq", {24'd0, o_snap_seq}, 32'd1);
        check_val("t1_cp_early", {29'd0, o_cp_cmplt}, 32'd0);
        i_snap_ack = 1'b1;
        @(negedge i_bus_clk);
        i_snap_ack = 1'b0;
        check_val("t1_cp", {29'd0, o_cp_cmplt}, 32'b100);
        check_val("t1_valid_clr", {31'd0, o_snap_valid}, 32'd0);
        check_val("t1_cnt_held", o_snap_cnt, 32'h1234);
        @(negedge i_bus_clk);
        i_ready = 3'b000;
        check_val("t1_cp_width", {29'd0, o_cp_cmplt}, 32'd0);
        idle_cycles(6);

        // Round robin: flags dropping right after the pulse, then persisting one cycle.
        run_three(1'b0, 2);
        run_three(1'b1, 5);

        // Acks in IDLE and CAPTURE are ignored.
        i_snap_ack = 1'b1;
        @(negedge i_bus_clk);
        check_val("ack_idle_valid", {31'd0, o_snap_valid}, 32'd0);
        check_val("ack_idle_cp", {29'd0, o_cp_cmplt}, 32'd0);
        i_read_cnt = 32'hDEAD_BEEF; i_read_req_cnt = 12'hABC; i_ready = 3'b010;
        idle_cycles(2);
        i_snap_ack = 1'b0;
        $display("txn read src=%0d cnt=0x%0h req=%0d seq=%0d", o_snap_src, o_snap_cnt, o_snap_req_cnt, o_snap_seq);
        check_val("ack_cap_valid", {31'd0, o_snap_valid}, 32'd1);
        check_val("ack_cap_src", {30'd0, o_snap_src}, 32'd1);
        check_val("ack_cap_cnt", o_snap_cnt, 32'hDEAD_BEEF);
        check_val("ack_cap_req", {20'd0, o_snap_req_cnt}, 32'hABC);
        check_val("ack_cap_seq", {24'd0, o_snap_seq}, 32'd8);
        idle_cycles(3);
        check_val("ack_wait_valid", {31'd0, o_snap_valid}, 32'd1);
        check_val("ack_wait_cp", {29'd0, o_cp_cmplt}, 32'd0);
        i_snap_ack = 1'b1;
        @(negedge i_bus_clk);
        i_snap_ack = 1'b0;
        check_val("ack_rel_cp", {29'd0, o_cp_cmplt}, 32'b010);
        @(negedge i_bus_clk);
        i_ready = 3'b000;
        idle_cycles(6);

        // Enable gating.
        i_enable = 1'b0; i_ready = 3'b010;
        idle_cycles(6);
        check_val("en_block_valid", {31'd0, o_snap_valid}, 32'd0);
        check_val("en_block_seq", {24'd0, o_snap_seq}, 32'd8);
        i_enable = 1'b1;
        idle_cycles(2);
        check_val("en_grant_valid", {31'd0, o_snap_valid}, 32'd1);
        check_val("en_grant_seq", {24'd0, o_snap_seq}, 32'd9);
        i_enable = 1'b0;
        @(negedge i_bus_clk);
        i_snap_ack = 1'b1;
        @(negedge i_bus_clk);
        i_snap_ack = 1'b0;
        $display("txn read_en_low cp=%b", o_cp_cmplt);
        check_val("en_drop_cp", {29'd0, o_cp_cmplt}, 32'b010);
        @(negedge i_bus_clk);
        i_ready = 3'b000; i_enable = 1'b1;
        idle_cycles(6);

        // Reset while waiting for ack.
        i_prog_cnt = 32'h55; i_ready = 3'b001;
        idle_cycles(2);
        check_val("rstw_valid_pre", {31'd0, o_snap_valid}, 32'd1);
        i_bus_rst = 1'b1;
        #1;
        check_val("rstw_valid", {31'd0, o_snap_valid}, 32'd0);
        check_val("rstw_seq", {24'd0, o_snap_seq}, 32'd0);
        check_val("rstw_cnt", o_snap_cnt, 32'd0);
        check_val("rstw_cp", {29'd0, o_cp_cmplt}, 32'd0);
        i_ready = 3'b000;
        @(negedge i_bus_clk);
        i_bus_rst = 1'b0;
        wait_cp(10, cp, at);
        check_val("rstw_no_cp", {29'd0, cp}, 32'd0);

        // Sequence number wrap after 256 snapshots.
        i_auto_ack = 1'b1; i_ready = 3'b001;
        for (int n = 1; n <= 256; n++) begin
            wait_cp(SPACING + 5, cp, at);
            $display("txn wrap n=%0d cp=%b seq=%0d", n, cp, o_snap_seq);
            check_val("wrap_cp", {29'd0, cp}, 32'b001);
            if (n == 255) check_val("wrap_seq_255", {24'd0, o_snap_seq}, 32'd255);
            if (n == 256) check_val("wrap_seq_0", {24'd0, o_snap_seq}, 32'd0);
        end
        i_ready = 3'b000; i_auto_ack = 1'b0;
        idle_cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
